// File: rtl/fifo_sync_ctrl.sv
//------------------------------------------------------------------------------
// Module      : fifo_sync_ctrl
// Description : Single-clock FIFO controller for an external LSRAM. It owns the
//               pointers, the occupancy count and the flags, and aligns DVLD
//               with the RAM read latency.
//               Optional: FIFO_SYNC_CTRL_ERR_FLAGS_EN adds OVERFLOW/UNDERFLOW.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fifo_sync_ctrl #(
   parameter int WIDTH      = 32,
   parameter int ADDR_WIDTH = 7,
   parameter int RD_LAT     = 1,
   parameter int AFULL_TH   = 120,
   parameter int AEMPTY_TH  = 8
) (
   input  logic                  CLOCK,
   input  logic                  RESET,
   input  logic                  WE,
   input  logic [WIDTH-1:0]      DATA,
   input  logic                  RE,
   output logic [WIDTH-1:0]      Q,
   output logic                  DVLD,
   output logic                  FULL,
   output logic                  EMPTY,
   output logic                  AFULL,
   output logic                  AEMPTY,
   output logic [ADDR_WIDTH:0]   COUNT,
`ifdef FIFO_SYNC_CTRL_ERR_FLAGS_EN
   output logic                  OVERFLOW,
   output logic                  UNDERFLOW,
`endif
   output logic [WIDTH-1:0]      RAM_WDATA,
   output logic [ADDR_WIDTH-1:0] RAM_WADDR,
   output logic                  RAM_WEN,
   output logic [ADDR_WIDTH-1:0] RAM_RADDR,
   output logic                  RAM_REN,
   input  logic [WIDTH-1:0]      RAM_RDATA
);

   localparam logic [ADDR_WIDTH:0] c_depth     = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] c_afull_th  = (ADDR_WIDTH+1)'(AFULL_TH);
   localparam logic [ADDR_WIDTH:0] c_aempty_th = (ADDR_WIDTH+1)'(AEMPTY_TH);
   localparam logic                c_afull_rst = (c_afull_th == '0);

   logic [ADDR_WIDTH-1:0] r_wptr;
   logic [ADDR_WIDTH-1:0] r_rptr;
   logic [ADDR_WIDTH:0]   r_count;
   logic                  r_full;
   logic                  r_empty;
   logic                  r_afull;
   logic                  r_aempty;
   logic [RD_LAT-1:0]     r_vld_pipe;

   logic                  w_wr_ok;
   logic                  w_rd_ok;
   logic [ADDR_WIDTH:0]   w_count_next;

   // FULL blocks writes even when a read is accepted in the same cycle.
   assign w_wr_ok = WE & ~r_full;
   assign w_rd_ok = RE & ~r_empty;
   assign w_count_next = r_count + {{ADDR_WIDTH{1'b0}}, w_wr_ok}
                                 - {{ADDR_WIDTH{1'b0}}, w_rd_ok};

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
         r_afull  <= c_afull_rst;
         r_aempty <= 1'b1;
      end else begin
         if (w_wr_ok) r_wptr <= r_wptr + 1'b1;
         if (w_rd_ok) r_rptr <= r_rptr + 1'b1;
         r_count  <= w_count_next;
         r_full   <= (w_count_next == c_depth);
         r_empty  <= (w_count_next == '0);
         r_afull  <= (w_count_next >= c_afull_th);
         r_aempty <= (w_count_next <= c_aempty_th);
      end
   end

   generate
      if (RD_LAT == 1) begin : g_lat_one
         always_ff @(posedge CLOCK or posedge RESET) begin
            if (RESET) r_vld_pipe <= '0;
            else       r_vld_pipe <= w_rd_ok;
         end
      end else begin : g_lat_multi
         always_ff @(posedge CLOCK or posedge RESET) begin
            if (RESET) r_vld_pipe <= '0;
            else       r_vld_pipe <= {r_vld_pipe[RD_LAT-2:0], w_rd_ok};
         end
      end
   endgenerate

`ifdef FIFO_SYNC_CTRL_ERR_FLAGS_EN
   logic r_overflow;
   logic r_underflow;

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_overflow  <= WE & r_full;
         r_underflow <= RE & r_empty;
      end
   end

   assign OVERFLOW  = r_overflow;
   assign UNDERFLOW = r_underflow;
`endif

   assign RAM_WEN   = w_wr_ok;
   assign RAM_WADDR = r_wptr;
   assign RAM_WDATA = DATA;
   assign RAM_REN   = w_rd_ok;
   assign RAM_RADDR = r_rptr;

   // Read data is not re-registered; the consumer samples it under DVLD.
   assign Q      = RAM_RDATA;
   assign DVLD   = r_vld_pipe[RD_LAT-1];
   assign FULL   = r_full;
   assign EMPTY  = r_empty;
   assign AFULL  = r_afull;
   assign AEMPTY = r_aempty;
   assign COUNT  = r_count;

endmodule

`default_nettype wire

// File: tb/tb_fifo_sync_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_fifo_sync_ctrl
// Description : Self-checking bench for fifo_sync_ctrl with a queue model and
//               a behavioural single-port-latency RAM.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fifo_sync_ctrl;

   localparam int c_w  = 8;
   localparam int c_aw = 4;
   localparam int c_depth = 16;

   logic            CLOCK = 1'b0;
   logic            RESET = 1'b1;
   logic            WE    = 1'b0;
   logic [c_w-1:0]  DATA  = '0;
   logic            RE    = 1'b0;
   logic [c_w-1:0]  Q;
   logic            DVLD, FULL, EMPTY, AFULL, AEMPTY;
   logic [c_aw:0]   COUNT;
   logic [c_w-1:0]  RAM_WDATA;
   logic [c_aw-1:0] RAM_WADDR;
   logic            RAM_WEN;
   logic [c_aw-1:0] RAM_RADDR;
   logic            RAM_REN;
   logic [c_w-1:0]  RAM_RDATA = '0;
`ifdef FIFO_SYNC_CTRL_ERR_FLAGS_EN
   logic            OVERFLOW, UNDERFLOW;
`endif

   int errors = 0;
   int checks = 0;

   fifo_sync_ctrl #(
      .WIDTH(c_w), .ADDR_WIDTH(c_aw), .RD_LAT(1), .AFULL_TH(14), .AEMPTY_TH(2)
   ) dut (
      .CLOCK(CLOCK), .RESET(RESET), .WE(WE), .DATA(DATA), .RE(RE),
      .Q(Q), .DVLD(DVLD), .FULL(FULL), .EMPTY(EMPTY), .AFULL(AFULL),
      .AEMPTY(AEMPTY), .COUNT(COUNT),
`ifdef FIFO_SYNC_CTRL_ERR_FLAGS_EN
      .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW),
`endif
      .RAM_WDATA(RAM_WDATA), .RAM_WADDR(RAM_WADDR), .RAM_WEN(RAM_WEN),
      .RAM_RADDR(RAM_RADDR), .RAM_REN(RAM_REN), .RAM_RDATA(RAM_RDATA)
   );

   always #5 CLOCK = ~CLOCK;

   // Behavioural RAM with one cycle of read latency.
   logic [c_w-1:0] mem [c_depth];
   always @(posedge CLOCK) begin
      if (RAM_WEN) mem[RAM_WADDR] <= RAM_WDATA;
      if (RAM_REN) RAM_RDATA <= mem[RAM_RADDR];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Queue model: contents, pending read result, and accepted-transfer counts.
   logic [c_w-1:0] m_fifo[$];
   bit             m_dvld = 0;
   logic [c_w-1:0] m_q    = '0;
   int             m_wcnt = 0;
   int             m_rcnt = 0;
   bit             m_ovf  = 0;
   bit             m_unf  = 0;

   always @(posedge CLOCK or posedge RESET) begin
      int  sz;
      bit  w, r;
      if (RESET) begin
         m_fifo.delete();
         m_dvld = 0;
         m_wcnt = 0;
         m_rcnt = 0;
         m_ovf  = 0;
         m_unf  = 0;
      end else begin
         sz = m_fifo.size();
         w  = WE && (sz < c_depth);
         r  = RE && (sz > 0);
         m_ovf  = WE && (sz == c_depth);
         m_unf  = RE && (sz == 0);
         m_dvld = r;
         if (r) begin
            m_q = m_fifo.pop_front();
            m_rcnt++;
         end
         if (w) begin
            m_fifo.push_back(DATA);
            m_wcnt++;
         end
      end
   end

   always @(negedge CLOCK) begin
      int sz;
      sz = m_fifo.size();
      chk("count",  32'(COUNT),  sz);
      chk("empty",  32'(EMPTY),  32'(sz == 0));
      chk("full",   32'(FULL),   32'(sz == c_depth));
      chk("afull",  32'(AFULL),  32'(sz >= 14));
      chk("aempty", 32'(AEMPTY), 32'(sz <= 2));
      chk("dvld",   32'(DVLD),   32'(m_dvld));
      if (m_dvld) chk("q", 32'(Q), 32'(m_q));
      chk("ram_wen", 32'(RAM_WEN), 32'(WE && (sz < c_depth)));
      chk("ram_ren", 32'(RAM_REN), 32'(RE && (sz > 0)));
      if (RAM_WEN) begin
         chk("ram_waddr", 32'(RAM_WADDR), m_wcnt % c_depth);
         chk("ram_wdata", 32'(RAM_WDATA), 32'(DATA));
      end
      if (RAM_REN) chk("ram_raddr", 32'(RAM_RADDR), m_rcnt % c_depth);
`ifdef FIFO_SYNC_CTRL_ERR_FLAGS_EN
      chk("overflow",  32'(OVERFLOW),  32'(m_ovf));
      chk("underflow", 32'(UNDERFLOW), 32'(m_unf));
`endif
   end

   // Apply one cycle of inputs; returns 1 time unit after the edge.
   task automatic cyc(input bit we, input logic [c_w-1:0] d, input bit re);
      WE = we; DATA = d; RE = re;
      @(posedge CLOCK);
      #1;
   endtask

   initial begin
      repeat (2) @(posedge CLOCK);
      #1 RESET = 1'b0;
      chk("rst_count",  32'(COUNT),  0);
      chk("rst_empty",  32'(EMPTY),  1);
      chk("rst_aempty", 32'(AEMPTY), 1);
      chk("rst_full",   32'(FULL),   0);
      chk("rst_afull",  32'(AFULL),  0);
      chk("rst_dvld",   32'(DVLD),   0);

      // Fill with 0x01..0x10.
      for (int i = 0; i < 16; i++) begin
         WE = 1'b1; DATA = 8'(i + 1); RE = 1'b0;
         #1 chk("fill_waddr", 32'(RAM_WADDR), i);
         @(posedge CLOCK);
         #1;
         chk("fill_empty",  32'(EMPTY),  0);
         chk("fill_aempty", 32'(AEMPTY), 32'(i + 1 <= 2));
         chk("fill_afull",  32'(AFULL),  32'(i + 1 >= 14));
         chk("fill_full",   32'(FULL),   32'(i + 1 == 16));
      end
      chk("full_count", 32'(COUNT), 16);

      // Write while full is dropped.
      WE = 1'b1; DATA = 8'hAA; RE = 1'b0;
      #1 chk("ovf_wen", 32'(RAM_WEN), 0);
      @(posedge CLOCK);
      #1 chk("ovf_count", 32'(COUNT), 16);
`ifdef FIFO_SYNC_CTRL_ERR_FLAGS_EN
      chk("ovf_pulse", 32'(OVERFLOW), 1);
      cyc(0, 8'h00, 0);
      chk("ovf_clear", 32'(OVERFLOW), 0);
`endif

      // Drain in order.
      for (int i = 0; i < 16; i++) begin
         cyc(0, 8'h00, 1);
         chk("drain_dvld", 32'(DVLD), 1);
         chk("drain_q",    32'(Q),    i + 1);
      end
      chk("drain_empty", 32'(EMPTY), 1);

      // Simultaneous write and read while empty: no fall-through.
      WE = 1'b1; DATA = 8'h55; RE = 1'b1;
      #1 chk("emp_ren", 32'(RAM_REN), 0);
      chk("emp_wen", 32'(RAM_WEN), 1);
      @(posedge CLOCK);
      #1 chk("emp_count", 32'(COUNT), 1);
      chk("emp_dvld", 32'(DVLD), 0);
`ifdef FIFO_SYNC_CTRL_ERR_FLAGS_EN
      chk("unf_pulse", 32'(UNDERFLOW), 1);
`endif
      cyc(0, 8'h00, 1);
      chk("emp_rd_dvld", 32'(DVLD), 1);
      chk("emp_rd_q",    32'(Q),    8'h55);

      // Half full, then streaming through the pointer wrap.
      for (int i = 0; i < 8; i++) cyc(1, 8'(8'h20 + i), 0);
      chk("half_count", 32'(COUNT), 8);
      for (int i = 0; i < 20; i++) begin
         cyc(1, 8'(8'h40 + i), 1);
         chk("stream_count", 32'(COUNT), 8);
         chk("stream_q", 32'(Q), (i < 8) ? (8'h20 + i) : (8'h40 + i - 8));
      end

      // Reset asynchronously with a read in flight.
      cyc(0, 8'h00, 1);
      chk("pre_rst_dvld", 32'(DVLD), 1);
      RE = 1'b0;
      #2 RESET = 1'b1;
      #1 chk("arst_dvld", 32'(DVLD), 0);
      chk("arst_count", 32'(COUNT), 0);
      chk("arst_empty", 32'(EMPTY), 1);
      @(posedge CLOCK);
      #1 RESET = 1'b0;
      WE = 1'b1; DATA = 8'h77; RE = 1'b0;
      #1 chk("post_rst_waddr", 32'(RAM_WADDR), 0);
      chk("post_rst_wen", 32'(RAM_WEN), 1);
      @(posedge CLOCK);
      #1;
      cyc(0, 8'h00, 1);
      chk("post_rst_q", 32'(Q), 8'h77);
      cyc(0, 8'h00, 0);
      repeat (2) @(posedge CLOCK);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
